// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: tracks in-flight destination tags in a shadow pipeline and
// raises register/flag stalls, with a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              two_src,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_s_bit,
    input  logic              id_uses_flags,
    input  logic              is_branch,
    input  logic              forward_en,
    input  logic              flush,
    input  logic              clear_stats,
    output logic              hazard_detected,
    output logic [2:0]        hazard_cause,
    output logic [CNT_W-1:0]  stall_count
);

    logic [DEPTH-1:0]  valid_q, wb_q, mem_q, s_q;
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DEPTH-1:0]  hit1, hit2;
    logic              raw1, raw2, rawf;
    logic              issue;
    logic [CNT_W-1:0]  count_q;

    // Stalled or squashed instructions enter the shadow pipeline as bubbles.
    assign issue = id_valid & ~flush & ~hazard_detected;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            wb_q    <= '0;
            mem_q   <= '0;
            s_q     <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dest_q[k] <= '0;
            end
        end else begin
            valid_q[0] <= issue;
            wb_q[0]    <= id_wb_en;
            mem_q[0]   <= id_mem_r_en;
            s_q[0]     <= id_s_bit;
            dest_q[0]  <= id_dest;
            for (int k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                wb_q[k]    <= wb_q[k-1];
                mem_q[k]   <= mem_q[k-1];
                s_q[k]     <= s_q[k-1];
                dest_q[k]  <= dest_q[k-1];
            end
        end
    end

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit1[k] = valid_q[k] & wb_q[k] & (dest_q[k] == src1);
            hit2[k] = valid_q[k] & wb_q[k] & (dest_q[k] == src2) & two_src;
        end
    end

    always_comb begin
        raw1 = 1'b0;
        raw2 = 1'b0;
        rawf = 1'b0;
        if (forward_en) begin
            // Only a load in EXE cannot be forwarded; branches resolve in ID with no bypass.
            raw1 = (hit1[0] & mem_q[0]) | (is_branch & (|hit1));
            raw2 = (hit2[0] & mem_q[0]) | (is_branch & (|hit2));
            rawf = id_uses_flags & valid_q[0] & s_q[0];
        end else begin
            raw1 = |hit1;
            raw2 = |hit2;
            rawf = id_uses_flags & (|(valid_q & s_q));
        end
    end

    assign hazard_detected = id_valid & ~flush & (raw1 | raw2 | rawf);
    assign hazard_cause    = hazard_detected ? {rawf, raw2, raw1} : 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_stats) begin
            count_q <= '0;
        end else if (hazard_detected && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign stall_count = count_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard detection unit for the ARM pipeline, placed in the ID stage. It replaces the stage-compare hazard logic with an internal shadow pipeline of destination tags, DEPTH entries deep. The tags cover every stage between ID and WB, so the unit is self-contained and needs no EXE/MEM destination inputs. It also detects status-flag (CPSR) hazards, reports the cause of each stall, and keeps a saturating stall-cycle counter for performance analysis.

## Interface
- ADDR_W, 4, register address width.
- DEPTH, 2, number of in-flight stages tracked between ID and WB (slot 0 = EXE, slot DEPTH-1 = last stage before WB); range 1..8.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- id_valid  input  1  ID holds a real instruction.
- src1  input  ADDR_W  first source register.
- src2  input  ADDR_W  second source register.
- two_src  input  1  src2 is read.
- id_dest  input  ADDR_W  destination of ID instruction.
- id_wb_en  input  1  ID instruction writes id_dest.
- id_mem_r_en  input  1  ID instruction is a load.
- id_s_bit  input  1  ID instruction updates flags.
- id_uses_flags  input  1  ID instruction is conditional / reads flags.
- is_branch  input  1  ID instruction is a branch.
- forward_en  input  1  forwarding unit enabled.
- flush  input  1  ID instruction is being squashed (taken branch).
- clear_stats  input  1  zero stall_count.
- hazard_detected  output  1  freeze PC and IF/ID, insert bubble.
- hazard_cause  output  3  {flags, src2, src1} conflict bits, valid when hazard_detected = 1, else 0.
- stall_count  output  CNT_W  saturating count of stall cycles.

## Operation
- Slot k holds valid, dest, wb_en, mem_r_en, s_bit.
- Every cycle the slots shift: slot k+1 <= slot k.
- Slot 0 is loaded as follows:
  - Bubble (valid = 0) if id_valid = 0, flush = 1, or hazard_detected = 1.
  - Otherwise the ID instruction's fields.
- The oldest slot drops out each cycle; it is written back at that point and no longer blocks.
- match_r(s,k) = slot[k].valid & slot[k].wb_en & (slot[k].dest == s).
- src2 comparisons are used only when two_src = 1.
- forward_en = 0:
  - src hazard if match_r against any slot.
  - flags hazard if id_uses_flags and any valid slot has s_bit = 1.
- forward_en = 1:
  - src hazard if match_r in slot 0 with mem_r_en = 1 (load-use).
  - src hazard if is_branch = 1 and match_r in any slot (branches read operands in ID, no forwarding path).
  - flags hazard only if id_uses_flags and slot 0 is valid with s_bit = 1.
- hazard_detected = id_valid & ~flush & (any src or flags hazard).
- hazard_cause is gated by hazard_detected.
- stall_count:
  - +1 each cycle hazard_detected = 1.
  - Saturates at 2^CNT_W-1.
  - clear_stats has priority and sets it to 0 that cycle, even when hazard_detected = 1.
- Register 15 (PC) gets no special treatment; comparison is purely by address.

## Timing
- hazard_detected and hazard_cause are combinational from inputs and registered slots, valid in the same cycle.
- An issued instruction is visible in slot 0 one cycle after issue.
- It blocks for at most DEPTH cycles with forwarding off, and exactly 1 cycle for load-use.
- Reset (rst_n = 0 at a clock edge):
  - All slots go invalid and stall_count goes to 0.
  - hazard_detected, hazard_cause = 0 on the cycle after reset.
  - Reset mid-stall discards all in-flight tags; no residual stall.
- A stalled instruction re-evaluates each cycle. Because bubbles advance, the stall clears deterministically.
- flush and hazard in the same cycle: flush wins, hazard_detected = 0, and a bubble is inserted.
- An ID instruction whose own id_dest equals its src is not a hazard; only slot entries are compared.
- id_wb_en = 0 entries never cause register hazards. id_s_bit = 0 entries never cause flag hazards.

## Test plan
1. **Reset:** fill slots with dest = 3, assert rst_n = 0 for 1 cycle, then present src1 = 3, id_valid = 1 -> hazard_detected = 0, stall_count = 0.
2. **No forwarding:** forward_en = 0. Issue dest = 3, wb_en = 1, then present src1 = 3 -> hazard_detected = 1 and cause = 3'b001 for 2 cycles, 0 on the 3rd; stall_count = 2.
3. **Load-use:** forward_en = 1. Issue a load to dest = 5, then present two_src = 1, src2 = 5 -> hazard for exactly 1 cycle, cause = 3'b010. Repeat with two_src = 0 -> no hazard.
4. **Branch and flags:** forward_en = 1. Issue dest = 2 (non-load), then is_branch = 1, src1 = 2 -> hazard for 2 cycles. Issue s_bit = 1, then id_uses_flags = 1 -> hazard for 1 cycle, cause = 3'b100.
5. **Flush:** issue dest = 4 with flush = 1, then present src1 = 4 -> no hazard. Also assert flush while a hazard exists -> hazard_detected = 0.
6. **Counter:** CNT_W = 4, 20 consecutive stall cycles -> stall_count = 15. Then clear_stats = 1 in a stall cycle -> 0 next cycle.
